// File: rtl/maj_seq_eval.sv
// maj_seq_eval: time-multiplexed MAJ3 network evaluator, one node per two cycles.
// Optional feature macro MAJ_SEQ_ERR_CHECK_EN: abort a run on bad operand refs.

module maj_seq_eval #(
    parameter int NUM_PI    = 4,
    parameter int MAX_NODES = 128,
    parameter int AW        = 7,
    parameter int IDX_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_we,
    input  logic [AW-1:0]          prog_addr,
    input  logic [3*(IDX_W+1)-1:0] prog_data,
    input  logic [AW:0]            num_nodes,
    input  logic [NUM_PI-1:0]      pi,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   po,
    output logic                   po_valid,
    output logic                   err
);

    localparam int OW = IDX_W + 1;
    localparam int PW = 3 * OW;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0]        mem [MAX_NODES];
    logic [PW-1:0]        ir;
    logic [MAX_NODES-1:0] nodes;
    logic [NUM_PI-1:0]    pi_l;
    logic [AW:0]          n_l;
    logic [AW-1:0]        pc;
    logic                 po_r;
    logic                 pov_r;

    logic [2:0]           opv;
    logic [2:0]           opbad;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     k;
    logic [NUM_PI-1:0]    psh;
    logic                 res;
    logic                 last;
    logic                 bad;
    logic                 accept;

    // Program store and instruction register; neither is reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_data;
        end
        if (state == FETCH) begin
            ir <= mem[pc];
        end
    end

    // Operand decode from the registered instruction and the node file.
    always_comb begin
        opv   = '0;
        opbad = '0;
        idx   = '0;
        k     = '0;
        psh   = '0;
        for (int i = 0; i < 3; i++) begin
            idx = ir[PW-2-i*OW -: IDX_W];
            k   = idx - IDX_W'(NUM_PI + 1);
            psh = pi_l >> (idx - 1'b1);
            if (idx == '0) begin
                opv[i] = 1'b0;
            end else if (idx <= IDX_W'(NUM_PI)) begin
                opv[i] = psh[0];
            end else if (idx <= IDX_W'(NUM_PI + MAX_NODES)) begin
                opv[i] = nodes[k[AW-1:0]];
`ifdef MAJ_SEQ_ERR_CHECK_EN
                opbad[i] = (k >= IDX_W'(pc));
`endif
            end else begin
                opv[i] = 1'b0;
`ifdef MAJ_SEQ_ERR_CHECK_EN
                opbad[i] = 1'b1;
`endif
            end
            opv[i] = opv[i] ^ ir[PW-1-i*OW];
        end
    end

    // Shared majority unit and end-of-program detect.
    always_comb begin
        res  = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
        last = ({1'b0, pc} == (n_l - 1'b1));
        bad  = |opbad;
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                state_nx = (n_l == '0) ? DONE : EVAL;
            end
            EVAL: begin
                busy     = 1'b1;
                state_nx = (bad || last) ? DONE : FETCH;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Run context, node file and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_l  <= '0;
            n_l   <= '0;
            pc    <= '0;
            nodes <= '0;
            po_r  <= 1'b0;
            pov_r <= 1'b0;
        end else begin
            if (accept) begin
                pi_l  <= pi;
                n_l   <= num_nodes;
                pc    <= '0;
                po_r  <= 1'b0;
                pov_r <= 1'b0;
            end
            if (state == EVAL) begin
                if (bad) begin
                    po_r <= 1'b0;
                end else begin
                    nodes[pc] <= res;
                    if (last) begin
                        po_r <= res;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
            end
            if (state != DONE && state_nx == DONE) begin
                pov_r <= 1'b1;
            end
        end
    end

`ifdef MAJ_SEQ_ERR_CHECK_EN
    logic err_r;

    // Sticky operand error, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= 1'b0;
        end else if (state == EVAL && bad) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign po       = po_r;
    assign po_valid = pov_r;

endmodule

// File: tb/tb_maj_seq_eval.sv
// tb_maj_seq_eval: randomized checks of maj_seq_eval against a node-list model.
// Honours MAJ_SEQ_ERR_CHECK_EN to select the abort expectations.

module tb_maj_seq_eval;

    localparam int NUM_PI    = 4;
    localparam int MAX_NODES = 128;
    localparam int AW        = 7;
    localparam int IDX_W     = 8;
    localparam int PW        = 27;

`ifdef MAJ_SEQ_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [PW-1:0] prog_data = '0;
    logic [AW:0]   num_nodes = '0;
    logic [3:0]    pi = '0;
    logic          start = 1'b0;
    logic          busy, done, po, po_valid, err;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] m_mem [MAX_NODES];
    logic          m_nodes [MAX_NODES];

    maj_seq_eval #(
        .NUM_PI(NUM_PI), .MAX_NODES(MAX_NODES), .AW(AW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .num_nodes(num_nodes), .pi(pi), .start(start),
        .busy(busy), .done(done), .po(po), .po_valid(po_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] enc(input logic ia, input int a,
                                          input logic ib, input int b,
                                          input logic ic, input int c);
        return {ia, 8'(a), ib, 8'(b), ic, 8'(c)};
    endfunction

    // Evaluate the stored program node by node as a list of MAJ3 gates.
    function automatic void model_run(input int n, input logic [3:0] p,
                                      output logic r_po, output int evals,
                                      output logic r_err);
        logic v [3];
        int   id, kk, ones;
        logic abort;
        r_po = 1'b0; evals = 0; r_err = 1'b0;
        for (int s = 0; s < n; s++) begin
            abort = 1'b0;
            evals++;
            for (int i = 0; i < 3; i++) begin
                id = int'((m_mem[s] >> (18 - 9 * i)) & 27'hff);
                if (id == 0) v[i] = 1'b0;
                else if (id <= NUM_PI) v[i] = p[id-1];
                else if (id <= NUM_PI + MAX_NODES) begin
                    kk = id - NUM_PI - 1;
                    v[i] = m_nodes[kk];
                    if (kk >= s) abort = 1'b1;
                end else begin
                    v[i] = 1'b0;
                    abort = 1'b1;
                end
                v[i] = v[i] ^ m_mem[s][26 - 9 * i];
            end
            if (abort && ERR_EN) begin
                r_err = 1'b1;
                r_po  = 1'b0;
                return;
            end
            ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
            m_nodes[s] = (ones >= 2);
            if (s == n - 1) r_po = (ones >= 2);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MAX_NODES; i++) m_nodes[i] = 1'b0;
    endfunction

    function automatic int pick(input int s);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 0;
        if (r < 5) return int'($urandom_range(1, 4));
        if (r < 9 && s > 0) return 5 + int'($urandom_range(0, s - 1));
        if (r < 9) return int'($urandom_range(1, 4));
        return int'($urandom_range(0, 255));
    endfunction

    task automatic prog(input int a, input logic [PW-1:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = 7'(a); prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        m_mem[a] = d;
    endtask

    // Start one run and observe it until the done pulse (bounded).
    task automatic run(input int n, input logic [3:0] p, output int lat,
                       output int bcnt, output logic o_po,
                       output logic o_pov, output logic o_err);
        @(posedge clk); #1;
        num_nodes = 8'(n); pi = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pi = 4'($urandom);
        lat = -1; bcnt = 0; o_po = 1'b0; o_pov = 1'b0; o_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = c; o_po = po; o_pov = po_valid; o_err = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (busy !== 1'b0) begin miscompares++;
            $display("FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++;
            $display("FAIL reset_done got %b want 0", done); end
        vectors++;
        if (po !== 1'b0) begin miscompares++;
            $display("FAIL reset_po got %b want 0", po); end
        vectors++;
        if (po_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_po_valid got %b want 0", po_valid); end
        vectors++;
        if (err !== 1'b0) begin miscompares++;
            $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_or_node();
        int lat, bc, ev; logic o, v, e, mp, me;
        logic [3:0] pv [2];
        logic       want [2];
        pv[0] = 4'b0001; want[0] = 1'b1;
        pv[1] = 4'b0000; want[1] = 1'b0;
        prog(0, enc(1'b0, 1, 1'b0, 2, 1'b1, 0));
        for (int t = 0; t < 2; t++) begin
            model_run(1, pv[t], mp, ev, me);
            run(1, pv[t], lat, bc, o, v, e);
            vectors++;
            if (o !== want[t]) begin miscompares++;
                $display("FAIL or_po pi=%b got %b want %b", pv[t], o, want[t]); end
            vectors++;
            if (lat != 2) begin miscompares++;
                $display("FAIL or_latency got %0d want 2", lat); end
            vectors++;
            if (v !== 1'b1) begin miscompares++;
                $display("FAIL or_po_valid got %b want 1", v); end
        end
    endtask

    task automatic prog_chain();
        prog(0, enc(1'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom), int'($urandom_range(0, 4))));
        prog(1, enc(1'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom), 5));
        prog(2, enc(1'b0, 5, 1'b1, 6, 1'b0, 4));
    endtask

    task automatic test_chain_all_pi();
        int lat, bc, ev; logic o, v, e, mp, me;
        prog_chain();
        for (int p = 0; p < 16; p++) begin
            model_run(3, 4'(p), mp, ev, me);
            run(3, 4'(p), lat, bc, o, v, e);
            vectors++;
            if (o !== mp) begin miscompares++;
                $display("FAIL chain_po pi=%0d got %b want %b", p, o, mp); end
            vectors++;
            if (bc != 6) begin miscompares++;
                $display("FAIL chain_busy pi=%0d got %0d want 6", p, bc); end
            vectors++;
            if (lat != 6) begin miscompares++;
                $display("FAIL chain_latency pi=%0d got %0d want 6", p, lat); end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin miscompares++;
                $display("FAIL chain_done_width got %b want 0", done); end
        end
    endtask

    task automatic test_zero_nodes();
        int lat, bc, ev; logic o, v, e, mp, me;
        prog(0, enc(1'b0, 1, 1'b0, 2, 1'b1, 0));
        model_run(1, 4'b0011, mp, ev, me);
        run(1, 4'b0011, lat, bc, o, v, e);
        model_run(0, 4'b1111, mp, ev, me);
        run(0, 4'b1111, lat, bc, o, v, e);
        vectors++;
        if (lat != 1) begin miscompares++;
            $display("FAIL zero_latency got %0d want 1", lat); end
        vectors++;
        if (o !== 1'b0) begin miscompares++;
            $display("FAIL zero_po got %b want 0", o); end
        vectors++;
        if (v !== 1'b1) begin miscompares++;
            $display("FAIL zero_po_valid got %b want 1", v); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ev, dones, first; logic o, v, e, mp, me, got;
        logic [3:0] p;
        prog_chain();
        p = 4'($urandom);
        model_run(3, p, mp, ev, me);
        @(posedge clk); #1;
        num_nodes = 8'd3; pi = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 27'($urandom);
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        dones = 0; first = -1; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) begin
                    first = c + 2; got = po;
                    start = 1'b1;
                end
            end
        end
        vectors++;
        if (dones != 1) begin miscompares++;
            $display("FAIL b2b_done_count got %0d want 1", dones); end
        vectors++;
        if (first != 6) begin miscompares++;
            $display("FAIL b2b_latency got %0d want 6", first); end
        vectors++;
        if (got !== mp) begin miscompares++;
            $display("FAIL b2b_po got %b want %b", got, mp); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++;
            $display("FAIL b2b_idle_busy got %b want 0", busy); end
        p = ~p;
        model_run(3, p, mp, ev, me);
        run(3, p, lat, bc, o, v, e);
        vectors++;
        if (o !== mp) begin miscompares++;
            $display("FAIL b2b_mem_kept got %b want %b", o, mp); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, ev; logic o, v, e, mp, me;
        logic [3:0] p;
        prog_chain();
        p = 4'($urandom);
        @(posedge clk); #1;
        num_nodes = 8'd3; pi = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++;
            $display("FAIL midrst_busy got %b want 0", busy); end
        vectors++;
        if (po !== 1'b0) begin miscompares++;
            $display("FAIL midrst_po got %b want 0", po); end
        vectors++;
        if (po_valid !== 1'b0) begin miscompares++;
            $display("FAIL midrst_po_valid got %b want 0", po_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL midrst_no_resume got %b%b want 00", busy, done); end
        model_run(3, p, mp, ev, me);
        run(3, p, lat, bc, o, v, e);
        vectors++;
        if (o !== mp || lat != 6) begin miscompares++;
            $display("FAIL midrst_rerun got po=%b lat=%0d want po=%b lat=6",
                     o, lat, mp); end
    endtask

    task automatic test_self_ref();
        int lat, bc, ev; logic o, v, e, mp, me;
        logic [3:0] p;
        prog(0, enc(1'b0, 1, 1'b0, 2, 1'b0, 3));
        prog(1, enc(1'b0, 6, 1'b0, 1, 1'b0, 2));
        prog(2, enc(1'b0, 5, 1'b1, 6, 1'b0, 4));
        p = 4'($urandom);
        model_run(3, p, mp, ev, me);
        run(3, p, lat, bc, o, v, e);
        vectors++;
        if (e !== ERR_EN) begin miscompares++;
            $display("FAIL selfref_err got %b want %b", e, ERR_EN); end
        vectors++;
        if (lat != (ERR_EN ? 4 : 6)) begin miscompares++;
            $display("FAIL selfref_latency got %0d want %0d", lat,
                     ERR_EN ? 4 : 6); end
        vectors++;
        if (o !== mp) begin miscompares++;
            $display("FAIL selfref_po got %b want %b", o, mp); end
        vectors++;
        if (v !== 1'b1) begin miscompares++;
            $display("FAIL selfref_po_valid got %b want 1", v); end
        model_run(1, p, mp, ev, me);
        run(1, p, lat, bc, o, v, e);
        vectors++;
        if (e !== 1'b0 || o !== mp) begin miscompares++;
            $display("FAIL selfref_clear got err=%b po=%b want err=0 po=%b",
                     e, o, mp); end
    endtask

    task automatic test_random();
        int lat, bc, ev, n, want_lat; logic o, v, e, mp, me;
        logic [3:0] p;
        for (int t = 0; t < 30; t++) begin
            n = int'($urandom_range(1, 8));
            for (int s = 0; s < n; s++) begin
                prog(s, enc(1'($urandom), pick(s), 1'($urandom), pick(s),
                            1'($urandom), pick(s)));
            end
            p = 4'($urandom);
            model_run(n, p, mp, ev, me);
            want_lat = 2 * ev;
            run(n, p, lat, bc, o, v, e);
            vectors++;
            if (o !== mp) begin miscompares++;
                $display("FAIL rand_po run=%0d got %b want %b", t, o, mp); end
            vectors++;
            if (lat != want_lat || bc != want_lat) begin miscompares++;
                $display("FAIL rand_timing run=%0d got lat=%0d busy=%0d want %0d",
                         t, lat, bc, want_lat); end
            vectors++;
            if (e !== me) begin miscompares++;
                $display("FAIL rand_err run=%0d got %b want %b", t, e, me); end
        end
    endtask

    initial begin
        test_reset();
        test_or_node();
        test_chain_all_pi();
        test_zero_nodes();
        test_back_to_back();
        test_reset_mid_run();
        test_self_ref();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
